// File: rtl/snake_pkg.sv
// Shared types for the snake game controller slice: game state
// encodings, collision codes and the step-period helper.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PLAY      = 2'b01,
        PAUSE     = 2'b10,
        GAME_OVER = 2'b11
    } state_e;

    localparam logic [1:0] COLLISION       = 2'b01;
    localparam logic [1:0] APPLE_COLLECTED = 2'b10;

    // max(minp, base - level*step) without going below zero
    function automatic int unsigned step_period(
        input int unsigned level,
        input int unsigned base,
        input int unsigned step,
        input int unsigned minp
    );
        int unsigned sub;
        sub = level * step;
        if (sub + minp >= base) begin
            return minp;
        end
        return base - sub;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Bundle between the game controller and its surroundings.
// master: controller side (takes frame_tick/buttons/collision,
// drives state, pulses, score, lives, level); slave: the far side.
interface snake_game_ctrl_if #(
    parameter int SCORE_DIGITS = 3,
    parameter int LIVES        = 3,
    parameter int MAX_LEVEL    = 6
);
    logic                              frame_tick;
    logic                              start_i;
    logic                              pause_i;
    logic [1:0]                        collision_i;
    logic [1:0]                        state_o;
    logic                              update_o;
    logic                              apple_trigger_o;
    logic                              snake_reset_o;
    logic [4*SCORE_DIGITS-1:0]         score_o;
    logic [$clog2(LIVES+1)-1:0]        lives_o;
    logic [$clog2(MAX_LEVEL+1)-1:0]    level_o;

    modport master (
        input  frame_tick, start_i, pause_i, collision_i,
        output state_o, update_o, apple_trigger_o, snake_reset_o,
        output score_o, lives_o, level_o
    );

    modport slave (
        output frame_tick, start_i, pause_i, collision_i,
        input  state_o, update_o, apple_trigger_o, snake_reset_o,
        input  score_o, lives_o, level_o
    );
endinterface

// File: rtl/snake_score_bcd.sv
// Saturating multi-digit BCD counter. Ports: clk, reset (sync,
// high), clear, inc; value_o holds digit 0 in bits [3:0].
module snake_score_bcd #(
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [4*DIGITS-1:0]   value_o
);
    logic [4*DIGITS-1:0] value_q, value_d;
    logic                carry;
    logic                all_nines;

    always_comb begin
        value_d   = value_q;
        carry     = 1'b1;
        all_nines = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value_q[4*i +: 4] != 4'd9) all_nines = 1'b0;
        end
        if (clear) begin
            value_d = '0;
        end else if (inc && !all_nines) begin
            // ripple the +1 through digits that wrap 9 -> 0
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (value_q[4*i +: 4] == 4'd9) begin
                        value_d[4*i +: 4] = 4'd0;
                    end else begin
                        value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
                        carry = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) value_q <= '0;
        else       value_q <= value_d;
    end

    assign value_o = value_q;
endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/PAUSE/GAME_OVER, lives, BCD
// score, level speed-up and frame-aligned control pulses. Ports:
// clk, reset (sync, high) and the bus interface (master side).
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int SCORE_DIGITS     = 3,
    parameter int LIVES            = 3,
    parameter int BASE_PERIOD      = 8,
    parameter int PERIOD_STEP      = 1,
    parameter int MIN_PERIOD       = 2,
    parameter int APPLES_PER_LEVEL = 4,
    parameter int MAX_LEVEL        = 6,
    parameter int GAMEOVER_FRAMES  = 120
) (
    input  logic               clk,
    input  logic               reset,
    snake_game_ctrl_if.master  bus
);
    localparam int LW   = $clog2(LIVES + 1);
    localparam int VW   = $clog2(MAX_LEVEL + 1);
    localparam int PMAX = (BASE_PERIOD > MIN_PERIOD) ? BASE_PERIOD : MIN_PERIOD;
    localparam int PW   = $clog2(PMAX + 1);
    localparam int AW   = $clog2(APPLES_PER_LEVEL + 1);
    localparam int GW   = $clog2(GAMEOVER_FRAMES + 1);

    state_e                  state_q, state_d;
    logic                    st_sync_q, st_prev_q;
    logic                    ps_sync_q, ps_prev_q;
    logic                    hit_q, hit_d;
    logic                    apple_q, apple_d;
    logic [LW-1:0]           lives_q, lives_d;
    logic [VW-1:0]           level_q, level_d;
    logic [AW-1:0]           apples_q, apples_d;
    logic [PW-1:0]           step_q, step_d;
    logic [GW-1:0]           go_q, go_d;
    logic                    update_q, update_d;
    logic                    atrig_q, atrig_d;
    logic                    sreset_q, sreset_d;
    logic                    score_clr, score_inc;
    logic [4*SCORE_DIGITS-1:0] score;

    logic        start_rise, pause_rise;
    logic        hit_now, apple_now, eval_tick, step_hit;
    logic [31:0] period;

    assign start_rise = st_sync_q & ~st_prev_q;
    assign pause_rise = ps_sync_q & ~ps_prev_q;
    // a code on the frame_tick cycle itself still counts
    assign hit_now    = hit_q | (bus.collision_i == COLLISION);
    assign apple_now  = apple_q | (bus.collision_i == APPLE_COLLECTED);
    assign eval_tick  = bus.frame_tick && (state_q == PLAY);
    assign period     = step_period(32'(level_q), BASE_PERIOD,
                                    PERIOD_STEP, MIN_PERIOD);
    // >= keeps stepping sane if a level-up shrank the period
    // below the current count
    assign step_hit   = (32'(step_q) + 32'd1) >= period;

    snake_score_bcd #(.DIGITS(SCORE_DIGITS)) u_score (
        .clk     (clk),
        .reset   (reset),
        .clear   (score_clr),
        .inc     (score_inc),
        .value_o (score)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start_rise) state_d = PLAY;
            PLAY: begin
                // a hit on this tick swallows a coincident pause edge
                if (eval_tick && hit_now) begin
                    if (lives_q == LW'(1)) state_d = GAME_OVER;
                end else if (pause_rise) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: if (pause_rise) state_d = PLAY;
            GAME_OVER: begin
                if (bus.frame_tick && go_q == GW'(GAMEOVER_FRAMES - 1))
                    state_d = IDLE;
            end
        endcase
    end

    always_comb begin : datapath
        hit_d     = hit_q;
        apple_d   = apple_q;
        lives_d   = lives_q;
        level_d   = level_q;
        apples_d  = apples_q;
        step_d    = step_q;
        go_d      = '0;
        update_d  = 1'b0;
        atrig_d   = 1'b0;
        sreset_d  = 1'b0;
        score_clr = 1'b0;
        score_inc = 1'b0;
        if (state_q == PLAY) begin
            hit_d   = hit_now;
            apple_d = apple_now;
        end
        if (bus.frame_tick) begin
            hit_d   = 1'b0;
            apple_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (start_rise) begin
                    lives_d   = LW'(LIVES);
                    level_d   = '0;
                    apples_d  = '0;
                    step_d    = '0;
                    hit_d     = 1'b0;
                    apple_d   = 1'b0;
                    score_clr = 1'b1;
                    sreset_d  = 1'b1;
                    atrig_d   = 1'b1;
                end
            end
            PLAY: begin
                if (eval_tick && hit_now) begin
                    lives_d = lives_q - LW'(1);
                    if (lives_q != LW'(1)) begin
                        sreset_d = 1'b1;
                        step_d   = '0;
                    end
                end else if (eval_tick) begin
                    if (apple_now) begin
                        score_inc = 1'b1;
                        atrig_d   = 1'b1;
                        if (apples_q == AW'(APPLES_PER_LEVEL - 1)) begin
                            apples_d = '0;
                            if (level_q != VW'(MAX_LEVEL))
                                level_d = level_q + VW'(1);
                        end else begin
                            apples_d = apples_q + AW'(1);
                        end
                    end
                    if (step_hit) begin
                        update_d = 1'b1;
                        step_d   = '0;
                    end else begin
                        step_d = step_q + PW'(1);
                    end
                end
            end
            GAME_OVER: begin
                go_d = bus.frame_tick ? go_q + GW'(1) : go_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_sync_q <= 1'b0;
            st_prev_q <= 1'b0;
            ps_sync_q <= 1'b0;
            ps_prev_q <= 1'b0;
            hit_q     <= 1'b0;
            apple_q   <= 1'b0;
            lives_q   <= LW'(LIVES);
            level_q   <= '0;
            apples_q  <= '0;
            step_q    <= '0;
            go_q      <= '0;
            update_q  <= 1'b0;
            atrig_q   <= 1'b0;
            sreset_q  <= 1'b0;
        end else begin
            st_sync_q <= bus.start_i;
            st_prev_q <= st_sync_q;
            ps_sync_q <= bus.pause_i;
            ps_prev_q <= ps_sync_q;
            hit_q     <= hit_d;
            apple_q   <= apple_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            apples_q  <= apples_d;
            step_q    <= step_d;
            go_q      <= go_d;
            update_q  <= update_d;
            atrig_q   <= atrig_d;
            sreset_q  <= sreset_d;
        end
    end

    always_comb begin : outputs
        bus.state_o         = state_q;
        bus.update_o        = update_q;
        bus.apple_trigger_o = atrig_q;
        bus.snake_reset_o   = sreset_q;
        bus.score_o         = score;
        bus.lives_o         = lives_q;
        bus.level_o         = level_q;
    end
endmodule

// File: tb/tb_snake_game_ctrl.sv
// Bench for snake_game_ctrl: directed game scenarios plus random
// button/collision traffic, compared cycle by cycle to a game model.
module tb_snake_game_ctrl;
    localparam int SD  = 3;
    localparam int LV  = 3;
    localparam int BP  = 8;
    localparam int PS  = 1;
    localparam int MP  = 2;
    localparam int APL = 4;
    localparam int ML  = 6;
    localparam int GOF = 120;
    localparam int FL  = 4;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_PAUSE = 2;
    localparam int S_OVER = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_game_ctrl_if #(.SCORE_DIGITS(SD), .LIVES(LV), .MAX_LEVEL(ML)) bus ();

    snake_game_ctrl #(
        .SCORE_DIGITS(SD), .LIVES(LV), .BASE_PERIOD(BP),
        .PERIOD_STEP(PS), .MIN_PERIOD(MP), .APPLES_PER_LEVEL(APL),
        .MAX_LEVEL(ML), .GAMEOVER_FRAMES(GOF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h",
                         tag, $time, got, exp);
        end
    endtask

    // game model: plain integers, decimal score
    int m_state, m_score, m_lives, m_level, m_apples, m_ticks, m_go;
    bit m_hit, m_apple, m_upd, m_atr, m_srs;
    bit s1, s2, p1, p2;

    bit       st_l, ps_l;
    bit [1:0] col_l;
    int       cnt = 0;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < SD; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_score = 0; m_lives = LV; m_level = 0;
        m_apples = 0; m_ticks = 0; m_go = 0;
        m_hit = 0; m_apple = 0; m_upd = 0; m_atr = 0; m_srs = 0;
        s1 = 0; s2 = 0; p1 = 0; p2 = 0;
    endtask

    task automatic model_step();
        bit se, pe, tick, hn, an;
        int per, maxs;
        if (reset) begin
            model_reset();
            return;
        end
        // buttons act one cycle after the first high sample
        se = s1 && !s2;
        pe = p1 && !p2;
        s2 = s1; s1 = bus.start_i;
        p2 = p1; p1 = bus.pause_i;
        tick = bus.frame_tick;
        m_upd = 0; m_atr = 0; m_srs = 0;
        maxs = 1;
        for (int i = 0; i < SD; i++) maxs = maxs * 10;
        maxs = maxs - 1;
        case (m_state)
            S_IDLE: begin
                if (se) begin
                    m_state = S_PLAY; m_score = 0; m_level = 0;
                    m_lives = LV; m_apples = 0; m_ticks = 0;
                    m_hit = 0; m_apple = 0; m_srs = 1; m_atr = 1;
                end else if (tick) begin
                    m_hit = 0; m_apple = 0;
                end
            end
            S_PLAY: begin
                hn = m_hit || (bus.collision_i == 2'b01);
                an = m_apple || (bus.collision_i == 2'b10);
                if (tick) begin
                    m_hit = 0; m_apple = 0;
                    if (hn) begin
                        m_lives--;
                        if (m_lives == 0) begin
                            m_state = S_OVER; m_go = 0;
                        end else begin
                            m_srs = 1; m_ticks = 0;
                        end
                    end else begin
                        per = BP - m_level * PS;
                        if (per < MP) per = MP;
                        if (an) begin
                            if (m_score < maxs) m_score++;
                            m_atr = 1;
                            m_apples++;
                            if (m_apples == APL) begin
                                m_apples = 0;
                                if (m_level < ML) m_level++;
                            end
                        end
                        m_ticks++;
                        if (m_ticks >= per) begin
                            m_upd = 1; m_ticks = 0;
                        end
                        if (pe) m_state = S_PAUSE;
                    end
                end else begin
                    m_hit = hn; m_apple = an;
                    if (pe) m_state = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (tick) begin m_hit = 0; m_apple = 0; end
                if (pe) m_state = S_PLAY;
            end
            default: begin
                if (tick) begin
                    m_go++;
                    if (m_go == GOF) m_state = S_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_all();
        check("state", 32'(bus.state_o), m_state);
        check("update", 32'(bus.update_o), 32'(m_upd));
        check("apple_trig", 32'(bus.apple_trigger_o), 32'(m_atr));
        check("snake_reset", 32'(bus.snake_reset_o), 32'(m_srs));
        check("score", 32'(bus.score_o), to_bcd(m_score));
        check("lives", 32'(bus.lives_o), m_lives);
        check("level", 32'(bus.level_o), m_level);
    endtask

    task automatic cyc();
        bus.frame_tick  = (cnt % FL == FL - 1);
        bus.start_i     = st_l;
        bus.pause_i     = ps_l;
        bus.collision_i = col_l;
        cnt++;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic align();
        while (cnt % FL != 0) cyc();
    endtask

    task automatic frames(input int n);
        repeat (n * FL) cyc();
    endtask

    task automatic press_start();
        st_l = 1; run(3); st_l = 0; run(1);
    endtask

    task automatic press_pause();
        ps_l = 1; run(3); ps_l = 0; run(1);
    endtask

    initial begin
        model_reset();
        st_l = 0; ps_l = 0; col_l = 2'b00;
        bus.frame_tick = 0; bus.start_i = 0;
        bus.pause_i = 0; bus.collision_i = 2'b00;
        reset = 1;
        run(3);
        reset = 0;
        run(3);

        // start, then plain stepping at level 0
        press_start();
        align();
        frames(24);

        // one apple per frame up through the level cap and beyond
        col_l = 2'b10;
        frames(32);
        col_l = 2'b00;
        frames(6);

        // hit and apple in the same frame
        align();
        col_l = 2'b10; run(2);
        col_l = 2'b01; run(2);
        col_l = 2'b00;
        frames(3);

        // pause with a held collision, then resume
        press_pause();
        col_l = 2'b01;
        frames(50);
        col_l = 2'b00;
        press_pause();
        frames(10);

        // lose every life, hold game over, back to idle
        col_l = 2'b01;
        frames(5);
        col_l = 2'b00;
        frames(GOF + 5);

        // drive the score to saturation
        press_start();
        col_l = 2'b10;
        frames(1005);
        col_l = 2'b00;
        frames(4);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            int r;
            if ($urandom_range(0, 19) == 0) st_l = ~st_l;
            if ($urandom_range(0, 29) == 0) ps_l = ~ps_l;
            r = int'($urandom_range(0, 99));
            col_l = (r < 8) ? 2'b01 : (r < 30) ? 2'b10 : 2'b00;
            cyc();
        end
        st_l = 0; ps_l = 0; col_l = 2'b00;
        run(4);

        // reset in the middle of a game
        if (m_state != S_PLAY) begin
            if (m_state == S_PAUSE) press_pause();
            else begin
                frames(GOF + 2);
                press_start();
            end
        end
        col_l = 2'b10;
        frames(3);
        reset = 1;
        run(1);
        reset = 0;
        col_l = 2'b00;
        run(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
